sram_read_back: RTL and testbench

Reads a diagonal-packed result matrix back out of SRAM bank a, b or c and streams it row by row, in ascending address order, to the downstream consumer. The SRAM rows are the ones the array's write-out stage produced, with lanes stored reversed. This block is the read side of the same SRAM interface: it issues addresses, absorbs the 1-cycle SRAM read latency, restores natural lane order, and presents a valid/ready stream with backpressure.

---
 rtl/systolic_array_pkg.sv | 10 +
 rtl/skid_fifo2.sv | 39 +++
 rtl/sram_read_back.sv | 112 +++++++++++
 tb/tb_sram_read_back.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// systolic_array_pkg: shared sizes, bank-select encodings and read-back FSM states
package systolic_array_pkg;
   localparam int DEF_ARRAY_SIZE = 16;
   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_ADDR_WIDTH = 6;
   localparam logic [1:0] SET_A = 2'd0;
   localparam logic [1:0] SET_C = 2'd1;
   localparam logic [1:0] SET_B = 2'd2;
   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry valid/ready buffer with occupancy count, head entry registered on the output
module skid_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);
   logic [WIDTH-1:0] e0_q, e1_q;
   logic [1:0]       cnt_q, cnt_d;
   logic             push, pop;
   assign out_valid = cnt_q != 2'd0;
   assign in_ready  = (cnt_q != 2'd2) || out_ready;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
   assign out_data  = e0_q;
   assign count     = cnt_q;
   // head refills from the second entry or directly from the input; second entry takes the input when it is the tail
   always_ff @(posedge clk) begin
      if (srst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         if ((cnt_q == 2'd0 && push) || (pop && (cnt_q == 2'd2 || push)))
            e0_q <= (cnt_q == 2'd2) ? e1_q : in_data;
         if (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop)))
            e1_q <= in_data;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/sram_read_back.sv
// sram_read_back: streams rows 0..num_rows-1 of one SRAM bank out with lanes restored to natural order
module sram_read_back
   import systolic_array_pkg::*;
#(
   parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             srst,
   input  logic                             start,
   input  logic [1:0]                       data_set,
   input  logic [ADDR_WIDTH-1:0]            num_rows,
   output logic [ADDR_WIDTH-1:0]            sram_raddr_a,
   output logic [ADDR_WIDTH-1:0]            sram_raddr_b,
   output logic [ADDR_WIDTH-1:0]            sram_raddr_c,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata_a,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata_b,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_rdata_c,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
   output logic                             out_last,
   output logic                             busy,
   output logic                             done
);
   localparam int W = ARRAY_SIZE * DATA_WIDTH;
   state_t                state_q;
   logic [1:0]            set_q;
   logic [ADDR_WIDTH-1:0] n_q, cnt_q, raddr_a_q, raddr_b_q, raddr_c_q;
   logic                  s1_q, s2_q, s2_d, done_q;
   logic                  push, pop, more, adv, last_in, accept, f_in_ready, f_valid;
   logic [1:0]            f_count;
   logic [2:0]            f_count_d;
   logic [W:0]            f_data;
   logic [W-1:0]          rdata_sel;
   // s1_q: the address register holds a freshly issued row; s2_q: rdata holds a row not yet captured.
   // A held address keeps re-reading the same row, so a pending row survives stalls without extra storage.
   assign rdata_sel = (set_q == SET_A) ? sram_rdata_a : (set_q == SET_C) ? sram_rdata_c : sram_rdata_b;
   assign more      = cnt_q != n_q;
   assign last_in   = !s1_q && !more;
   assign push      = s2_q && f_in_ready;
   assign pop       = f_valid && out_ready;
   assign f_count_d = {1'b0, f_count} + {2'b0, push} - {2'b0, pop};
   assign s2_d      = s1_q || (s2_q && !push);
   assign adv       = (state_q == ST_READ) && more && (!s2_d || f_count_d < 3'd2);
   assign accept    = start && (data_set != 2'd3) && (num_rows != '0);
   skid_fifo2 #(.WIDTH(W + 1)) u_fifo (
      .clk      (clk),
      .srst     (srst),
      .in_valid (s2_q),
      .in_data  ({last_in, rdata_sel}),
      .in_ready (f_in_ready),
      .out_valid(f_valid),
      .out_ready(out_ready),
      .out_data (f_data),
      .count    (f_count)
   );
   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_rev
      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = f_data[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH];
   end
   assign out_valid    = f_valid;
   assign out_last     = f_data[W];
   assign busy         = state_q != ST_IDLE;
   assign done         = done_q;
   assign sram_raddr_a = raddr_a_q;
   assign sram_raddr_b = raddr_b_q;
   assign sram_raddr_c = raddr_c_q;
   // request FSM, address issue into the latched bank and read-pipeline tracking
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q   <= ST_IDLE;
         set_q     <= '0;
         n_q       <= '0;
         cnt_q     <= '0;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         raddr_a_q <= '0;
         raddr_b_q <= '0;
         raddr_c_q <= '0;
         done_q    <= 1'b0;
      end else begin
         s1_q   <= adv;
         s2_q   <= s2_d;
         done_q <= 1'b0;
         if (adv) begin
            cnt_q     <= cnt_q + ADDR_WIDTH'(1);
            raddr_a_q <= (set_q == SET_A) ? cnt_q : raddr_a_q;
            raddr_b_q <= (set_q == SET_B) ? cnt_q : raddr_b_q;
            raddr_c_q <= (set_q == SET_C) ? cnt_q : raddr_c_q;
         end
         case (state_q)
            ST_IDLE: if (accept) begin
               state_q   <= ST_READ;
               set_q     <= data_set;
               n_q       <= num_rows;
               cnt_q     <= ADDR_WIDTH'(1);
               s1_q      <= 1'b1;
               raddr_a_q <= '0;
               raddr_b_q <= '0;
               raddr_c_q <= '0;
            end
            ST_READ: if (!more) state_q <= ST_DRAIN;
            ST_DRAIN: if (pop && f_data[W]) begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_read_back.sv
// tb_sram_read_back: table-driven and randomized read-back requests checked against a row-queue model
module tb_sram_read_back;
   localparam int W = 384;
   typedef struct {
      logic [1:0] ds;
      logic [5:0] n;
      int         pct;
      bit         busy_start;
      bit         ramp;
   } vec_t;
   logic         clk = 1'b0;
   logic         srst, start, out_ready, out_valid, out_last, busy, done;
   logic [1:0]   data_set;
   logic [5:0]   num_rows, ra, rb, rc;
   logic [W-1:0] rda, rdb, rdc, out_data;
   logic [W-1:0] mem [3][64];
   int           checks = 0, errors = 0;
   vec_t         tv [10];

   sram_read_back dut (
      .clk(clk), .srst(srst), .start(start), .data_set(data_set), .num_rows(num_rows),
      .sram_raddr_a(ra), .sram_raddr_b(rb), .sram_raddr_c(rc),
      .sram_rdata_a(rda), .sram_rdata_b(rdb), .sram_rdata_c(rdc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rda <= mem[0][ra];
      rdb <= mem[1][rb];
      rdc <= mem[2][rc];
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int bank_of(input logic [1:0] ds);
      return (ds == 2'd0) ? 0 : (ds == 2'd1) ? 2 : 1;
   endfunction

   function automatic logic [W-1:0] rev(input logic [W-1:0] r);
      logic [W-1:0] o;
      for (int i = 0; i < 16; i++) o[i*24 +: 24] = r[(15-i)*24 +: 24];
      return o;
   endfunction

   task automatic run_req(input vec_t v);
      int           b, acc, cyc, hs_cyc, maxa;
      bit           go, fin, prev_stall, prev_last, ok_addr, ok_sel0;
      logic [W-1:0] prev_data;
      logic [W-1:0] expq [$];
      logic [5:0]   sa, pa, ra0, rb0, rc0;
      b = bank_of(v.ds);
      for (int k = 0; k < 64; k++)
         for (int j = 0; j < 16; j++)
            mem[b][k][j*24 +: 24] = v.ramp ? 24'(k*16 + j) : 24'($urandom);
      go = (v.ds != 2'd3) && (v.n != 6'd0);
      for (int k = 0; k < int'(v.n); k++) expq.push_back(rev(mem[b][k]));
      ra0 = ra; rb0 = rb; rc0 = rc;
      @(negedge clk);
      data_set = v.ds; num_rows = v.n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (!go) begin
         for (int c = 0; c < 6; c++) begin
            chk("ignored_busy", busy, 0);
            chk("ignored_done", done, 0);
            chk("ignored_addr", {ra, rb, rc}, {ra0, rb0, rc0});
            @(negedge clk);
         end
         return;
      end
      chk("busy_rise", busy, 1);
      cyc = 1; acc = 0; hs_cyc = -1; maxa = 0; pa = 0;
      fin = 0; prev_stall = 0; prev_last = 0; prev_data = '0; ok_addr = 1; ok_sel0 = 1;
      while (!fin) begin
         if (hs_cyc >= 0) begin
            chk("done_pulse", done, 1);
            chk("busy_fall", busy, 0);
            if (v.pct == 100) chk("done_cycle", cyc, 3 + int'(v.n));
            fin = 1;
         end else begin
            if (done) chk("early_done", done, 0);
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, prev_data);
               chk("stall_last", out_last, prev_last);
            end
            sa = (b == 0) ? ra : (b == 1) ? rb : rc;
            if (sa < pa || int'(sa) > int'(pa) + 1 || int'(sa) > acc + 2) ok_addr = 0;
            if ((b != 0 && ra != 0) || (b != 1 && rb != 0) || (b != 2 && rc != 0)) ok_sel0 = 0;
            if (int'(sa) > maxa) maxa = int'(sa);
            pa = sa;
            out_ready = (v.pct < 0) ? (cyc % 4 == 0 || cyc % 4 == 3) : ($urandom_range(99) < v.pct);
            if (v.busy_start && cyc == 2) begin
               start = 1'b1; data_set = v.ds ^ 2'd1; num_rows = 6'd5;
            end else start = 1'b0;
            if (out_valid && out_ready) begin
               if (acc == 0 && v.pct == 100) chk("first_latency", cyc, 3);
               if (acc < int'(v.n)) begin
                  chk("row_data", out_data, expq[acc]);
                  chk("row_last", out_last, acc == int'(v.n) - 1);
               end else chk("extra_row", acc, v.n);
               if (out_last) hs_cyc = cyc;
               acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
         end
         if (!fin && cyc > 3000) begin
            checks++; errors++;
            $display("FAIL timeout: accepted %0d of %0d rows", acc, v.n);
            fin = 1;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0; start = 1'b0;
      chk("row_count", acc, v.n);
      chk("addr_order", ok_addr, 1);
      chk("unsel_zero", ok_sel0, 1);
      chk("max_addr", maxa, int'(v.n) - 1);
   endtask

   initial begin
      int acc;
      tv[0] = '{2'd0, 6'd31, 100, 1'b0, 1'b1};
      tv[1] = '{2'd1, 6'd8,  -1,  1'b0, 1'b0};
      tv[2] = '{2'd3, 6'd5,  100, 1'b0, 1'b0};
      tv[3] = '{2'd0, 6'd0,  100, 1'b0, 1'b0};
      tv[4] = '{2'd2, 6'd1,  100, 1'b0, 1'b0};
      tv[5] = '{2'd0, 6'd10, 100, 1'b1, 1'b0};
      tv[6] = '{2'd2, 6'd63, 100, 1'b0, 1'b0};
      tv[7] = '{2'd1, 6'($urandom_range(2, 40)), 60, 1'b0, 1'b0};
      tv[8] = '{2'd2, 6'($urandom_range(2, 40)), 30, 1'b0, 1'b0};
      tv[9] = '{2'd0, 6'd16, 100, 1'b0, 1'b0};
      for (int b = 0; b < 3; b++)
         for (int k = 0; k < 64; k++) mem[b][k] = '0;
      srst = 1'b1; start = 1'b0; out_ready = 1'b0; data_set = '0; num_rows = '0;
      repeat (3) @(negedge clk);
      chk("reset_addr", {ra, rb, rc}, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_last", out_last, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      srst = 1'b0;
      @(negedge clk);
      for (int t = 0; t < 9; t++) begin
         run_req(tv[t]);
         repeat (2) @(negedge clk);
      end
      for (int k = 0; k < 64; k++) mem[0][k] = {12{32'($urandom)}};
      data_set = 2'd0; num_rows = 6'd16; start = 1'b1;
      @(negedge clk);
      start = 1'b0; acc = 0;
      for (int c = 0; c < 30; c++) begin
         out_ready = acc < 5;
         if (out_valid && out_ready) begin
            chk("pre_reset_row", out_data, rev(mem[0][acc]));
            acc++;
         end
         @(negedge clk);
      end
      chk("pre_reset_stalled", out_valid, 1);
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      chk("midrst_addr", {ra, rb, rc}, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_last", out_last, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      for (int c = 0; c < 4; c++) begin
         out_ready = 1'b1;
         chk("post_rst_done", done, 0);
         chk("post_rst_valid", out_valid, 0);
         @(negedge clk);
      end
      out_ready = 1'b0;
      run_req(tv[9]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
